// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan driver: FSM states, RGB565 field layout,
// panel geometry defaults and pixel RAM address packing.
package hub75_pkg;

  localparam int COLS_DEF      = 64;
  localparam int HALF_ROWS_DEF = 32;
  localparam int COL_W         = 6;
  localparam int ROW_W         = 5;
  localparam int ADDR_W        = 1 + ROW_W + COL_W;
  localparam int CH_W          = 5;

  localparam int R_LSB = 11;
  localparam int G_LSB = 6;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb555_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic             half,
                                                  input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {half, row, col};
  endfunction

  // Green is reduced to 5 bits so all three channels share one set of bit planes.
  function automatic rgb555_t unpack_565(input logic [15:0] d);
    rgb555_t p;
    logic    unused_g_lsb;
    unused_g_lsb = d[G_LSB-1];
    p.r = d[R_LSB +: CH_W];
    p.g = d[G_LSB +: CH_W];
    p.b = d[B_LSB +: CH_W];
    return p;
  endfunction

endpackage

// File: rtl/hub75_pixel_fetch.sv
// Column sequencer for one shift pass: two RAM reads per column (upper then lower half),
// pixel capture, and per-plane colour bits plus shift clock for the panel.
module hub75_pixel_fetch
  import hub75_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int PLANE_W = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_active,
  input  logic [ROW_W-1:0]   i_row,
  input  logic [PLANE_W-1:0] i_plane,
  input  logic [15:0]        i_r_data,
  output logic [ADDR_W-1:0]  o_r_addr,
  output logic               o_r_enable,
  output logic               o_sclk,
  output logic               o_done,
  output logic               o_r1,
  output logic               o_g1,
  output logic               o_b1,
  output logic               o_r2,
  output logic               o_g2,
  output logic               o_b2
);

  logic [1:0]       r_phase;
  logic [COL_W-1:0] r_col;
  rgb555_t          r_up;
  rgb555_t          r_lo;
  rgb555_t          w_lo;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_col   <= '0;
      r_up    <= '0;
      r_lo    <= '0;
    end else if (!i_active) begin
      r_phase <= '0;
      r_col   <= '0;
    end else begin
      r_phase <= r_phase + 2'd1;
      if (r_phase == 2'd3) begin
        r_col <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
      end
      if (r_phase == 2'd1) r_up <= unpack_565(i_r_data);
      if (r_phase == 2'd2) r_lo <= unpack_565(i_r_data);
    end
  end

  // Lower pixel arrives in C2; pass it straight through so both halves are valid a full
  // cycle before the sclk rising edge in C3.
  always_comb begin
    w_lo       = (i_active && r_phase == 2'd2) ? unpack_565(i_r_data) : r_lo;
    o_r_addr   = i_active ? pack_addr(r_phase[0], i_row, r_col) : '0;
    o_r_enable = i_active && !r_phase[1];
    o_sclk     = i_active && (r_phase == 2'd3);
    o_done     = i_active && (r_phase == 2'd3) && (r_col == COL_W'(COLS - 1));
    o_r1       = r_up.r[i_plane];
    o_g1       = r_up.g[i_plane];
    o_b1       = r_up.b[i_plane];
    o_r2       = w_lo.r[i_plane];
    o_g2       = w_lo.g[i_plane];
    o_b2       = w_lo.b[i_plane];
  end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 64x64 1/32-scan panel driver: row/plane sequencing, latch and BCM output-enable
// timing around the pixel fetch shift pass.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int COLS       = COLS_DEF,
  parameter int HALF_ROWS  = HALF_ROWS_DEF,
  parameter int PLANES     = 5,
  parameter int BASE_TICKS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_r_addr,
  output logic              o_r_enable,
  input  logic [15:0]       i_r_data,
  output logic              o_r1,
  output logic              o_g1,
  output logic              o_b1,
  output logic              o_r2,
  output logic              o_g2,
  output logic              o_b2,
  output logic [ROW_W-1:0]  o_row,
  output logic              o_sclk,
  output logic              o_lat,
  output logic              o_oe_n,
  output logic              o_frame_done
);

  localparam int PLANE_W = $clog2(PLANES);
  localparam int CNT_W   = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

  state_t             r_state;
  logic [ROW_W-1:0]   r_row_cnt;
  logic [ROW_W-1:0]   r_row;
  logic [PLANE_W-1:0] r_plane;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_lat;
  logic               r_oe_n;
  logic               r_frame_done;
  logic               w_active;
  logic               w_done;

  assign w_active = (r_state == ST_SHIFT);

  hub75_pixel_fetch #(
    .COLS    (COLS),
    .PLANE_W (PLANE_W)
  ) u_fetch (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_active   (w_active),
    .i_row      (r_row_cnt),
    .i_plane    (r_plane),
    .i_r_data   (i_r_data),
    .o_r_addr   (o_r_addr),
    .o_r_enable (o_r_enable),
    .o_sclk     (o_sclk),
    .o_done     (w_done),
    .o_r1       (o_r1),
    .o_g1       (o_g1),
    .o_b1       (o_b1),
    .o_r2       (o_r2),
    .o_g2       (o_g2),
    .o_b2       (o_b2)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_row_cnt    <= '0;
      r_row        <= '0;
      r_plane      <= '0;
      r_cnt        <= '0;
      r_lat        <= 1'b0;
      r_oe_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_oe_n <= 1'b1;
          if (i_enable) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_done) begin
            r_state <= ST_LATCH;
            r_lat   <= 1'b1;
            r_row   <= r_row_cnt;
          end
        end
        ST_LATCH: begin
          r_state <= ST_DISPLAY;
          r_lat   <= 1'b0;
          r_oe_n  <= 1'b0;
          r_cnt   <= CNT_W'((BASE_TICKS << r_plane) - 1);
        end
        ST_DISPLAY: begin
          if (r_cnt == '0) begin
            r_oe_n <= 1'b1;
            if (r_plane == PLANE_W'(PLANES - 1)) begin
              r_plane <= '0;
              if (r_row_cnt == ROW_W'(HALF_ROWS - 1)) begin
                r_row_cnt    <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_row_cnt <= r_row_cnt + 1'b1;
              end
            end else begin
              r_plane <= r_plane + 1'b1;
            end
            // Enable only matters at a period boundary; stopping restarts the frame.
            if (i_enable) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state   <= ST_IDLE;
              r_row_cnt <= '0;
              r_plane   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_row        = r_row;
  assign o_lat        = r_lat;
  assign o_oe_n       = r_oe_n;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver: start-up vector table, per-plane scoreboard of
// shifted colour bits, BCM/latch/row timing, frame period, enable drop and reset cases.
module tb_hub75_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] o_r_addr;
  logic        o_r_enable;
  logic [15:0] r_data = '0;
  logic        o_r1, o_g1, o_b1, o_r2, o_g2, o_b2;
  logic [4:0]  o_row;
  logic        o_sclk, o_lat, o_oe_n, o_frame_done;

  logic [15:0] mem [4096];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_r_enable) r_data <= mem[o_r_addr];

  hub75_scan_driver #(
    .COLS       (64),
    .HALF_ROWS  (32),
    .PLANES     (5),
    .BASE_TICKS (8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .o_r_addr     (o_r_addr),
    .o_r_enable   (o_r_enable),
    .i_r_data     (r_data),
    .o_r1         (o_r1),
    .o_g1         (o_g1),
    .o_b1         (o_b1),
    .o_r2         (o_r2),
    .o_g2         (o_g2),
    .o_b2         (o_b2),
    .o_row        (o_row),
    .o_sclk       (o_sclk),
    .o_lat        (o_lat),
    .o_oe_n       (o_oe_n),
    .o_frame_done (o_frame_done)
  );

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int           row;
    int           plane;
    logic [191:0] up;
    logic [191:0] lo;
  } exp_t;

  exp_t exp_q[$];

  // Bit order per vector: [c]=R, [64+c]=G, [128+c]=B for column c.
  function automatic exp_t mk(input int row, input int plane);
    exp_t        e;
    logic [15:0] u, l;
    e.row   = row;
    e.plane = plane;
    e.up    = '0;
    e.lo    = '0;
    for (int c = 0; c < 64; c++) begin
      u = mem[{1'b0, 5'(row), 6'(c)}];
      l = mem[{1'b1, 5'(row), 6'(c)}];
      e.up[c]       = u[11 + plane];
      e.up[64 + c]  = u[6 + plane];
      e.up[128 + c] = u[plane];
      e.lo[c]       = l[11 + plane];
      e.lo[64 + c]  = l[6 + plane];
      e.lo[128 + c] = l[plane];
    end
    return e;
  endfunction

  // Output monitor, sampled on the falling edge.
  logic [191:0] got_up, got_lo;
  int   sclk_cnt  = 0;
  int   run       = 0;
  int   lat_count = 0;
  int   fd_count  = 0;
  int   fd_cyc    = 0;
  logic prev_sclk = 1'b0;
  logic prev_oe   = 1'b1;
  logic prev_lat  = 1'b0;
  logic row_moved = 1'b0;
  logic [4:0] row_at_start = '0;
  exp_t cur = '{row: 0, plane: 0, up: '0, lo: '0};

  always @(negedge clk) begin
    if (!rst_n) begin
      sclk_cnt  = 0;
      run       = 0;
      prev_sclk = 1'b0;
      prev_oe   = 1'b1;
      prev_lat  = 1'b0;
    end else begin
      if (o_frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (o_sclk && !prev_sclk) begin
        if (sclk_cnt < 64) begin
          got_up[sclk_cnt]       = o_r1;
          got_up[64 + sclk_cnt]  = o_g1;
          got_up[128 + sclk_cnt] = o_b1;
          got_lo[sclk_cnt]       = o_r2;
          got_lo[64 + sclk_cnt]  = o_g2;
          got_lo[128 + sclk_cnt] = o_b2;
        end
        sclk_cnt++;
      end
      if (o_lat) begin
        if (prev_lat) chk("lat_single", 192'(1), 192'(0));
        if (exp_q.size() == 0) begin
          chk("lat_unexpected", 192'(lat_count), 192'(-1));
        end else begin
          cur = exp_q.pop_front();
          chk("row_at_lat", 192'(o_row), 192'(cur.row));
          chk("sclk_per_lat", 192'(sclk_cnt), 192'(64));
          chk("upper_bits", got_up, cur.up);
          chk("lower_bits", got_lo, cur.lo);
          if (cur.row == 0)
            chk("col5_pixel", 192'({got_up[5], got_up[69], got_lo[133], got_lo[5]}),
                192'(4'b1010));
        end
        sclk_cnt = 0;
        lat_count++;
      end
      if (!o_oe_n) begin
        if (prev_oe) begin
          chk("lat_before_oe", 192'(prev_lat), 192'(1));
          run          = 0;
          row_at_start = o_row;
          row_moved    = 1'b0;
        end
        run++;
        if (o_row != row_at_start) row_moved = 1'b1;
      end else if (!prev_oe) begin
        chk("oe_run_len", 192'(run), 192'(8 << cur.plane));
        chk("row_stable_disp", 192'(row_moved), 192'(0));
      end
      prev_sclk = o_sclk;
      prev_oe   = o_oe_n;
      prev_lat  = o_lat;
    end
  end

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        chk_addr;
    logic [11:0] addr;
    logic        ren;
    logic        sclk;
    logic        oe_n;
    logic        lat;
  } vec_t;

  vec_t tbl [10];
  int   t0, lx, l0;
  logic idle_bad;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    mem[12'h005] = 16'hF800;
    mem[12'h805] = 16'h001F;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 12'h800, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 12'h801, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    for (int r = 0; r < 32; r++)
      for (int p = 0; p < 5; p++) exp_q.push_back(mk(r, p));

    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      @(posedge clk);
      #1;
      if (i == 2) t0 = cyc;
      if (i == 0)
        chk("reset_misc", 192'({o_r1, o_g1, o_b1, o_r2, o_g2, o_b2, o_row, o_frame_done}),
            192'(0));
      chk($sformatf("vec%0d", i),
          192'({tbl[i].chk_addr ? o_r_addr : 12'h000, o_r_enable, o_sclk, o_oe_n, o_lat}),
          192'({tbl[i].chk_addr ? tbl[i].addr : 12'h000, tbl[i].ren, tbl[i].sclk,
                tbl[i].oe_n, tbl[i].lat}));
    end

    // Full frame.
    for (int k = 0; k < 50000 && fd_count == 0; k++) @(negedge clk);
    chk("frame_seen", 192'(fd_count), 192'(1));
    chk("frame_period", 192'(fd_cyc - t0), 192'(49056));
    chk("frame_lats", 192'(lat_count), 192'(160));
    chk("frame_q_empty", 192'(exp_q.size()), 192'(0));

    // Drop enable in the middle of row 1 plane 1's shift.
    l0 = lat_count;
    for (int p = 0; p < 5; p++) exp_q.push_back(mk(0, p));
    exp_q.push_back(mk(1, 0));
    exp_q.push_back(mk(1, 1));
    for (int k = 0; k < 3000 && lat_count < l0 + 6; k++) @(negedge clk);
    chk("wait_row1_p0", 192'(lat_count), 192'(l0 + 6));
    repeat (120) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 400 && lat_count < l0 + 7; k++) @(negedge clk);
    chk("wait_row1_p1", 192'(lat_count), 192'(l0 + 7));
    for (int k = 0; k < 20 && o_oe_n; k++) @(negedge clk);
    for (int k = 0; k < 200 && !o_oe_n; k++) @(negedge clk);
    chk("disp_done_oe", 192'(o_oe_n), 192'(1));
    idle_bad = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (o_sclk || !o_oe_n || o_r_enable || o_lat) idle_bad = 1'b1;
    end
    chk("idle_quiet", 192'(idle_bad), 192'(0));
    chk("idle_lats", 192'(lat_count), 192'(l0 + 7));
    chk("idle_q_empty", 192'(exp_q.size()), 192'(0));

    // Re-enable restarts at row 0 plane 0.
    lx = lat_count;
    exp_q.push_back(mk(0, 0));
    exp_q.push_back(mk(0, 1));
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_addr", 192'({o_r_addr, o_r_enable}), 192'({12'h000, 1'b1}));
    for (int k = 0; k < 800 && lat_count < lx + 2; k++) @(negedge clk);
    chk("wait_restart", 192'(lat_count), 192'(lx + 2));
    for (int k = 0; k < 20 && o_oe_n; k++) @(negedge clk);
    chk("in_display", 192'(o_oe_n), 192'(0));
    repeat (5) @(negedge clk);

    // Reset mid-display.
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_oe_off", 192'(o_oe_n), 192'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs",
        192'({o_r_addr, o_r_enable, o_sclk, o_lat, o_oe_n, o_row, o_frame_done}),
        192'({12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}));
    chk("end_q_empty", 192'(exp_q.size()), 192'(0));
    chk("frame_count", 192'(fd_count), 192'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
